// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, 8x16 register file, BEQ/BNE resolution,
// fetch control and a registered ID/EX bundle with valid/ready flow control.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  if_pc,
    input  logic [15:0] if_instr,
    input  logic        if_valid,
    output logic        instr_fetch_enable,
    output logic        branch_enable,
    output logic [5:0]  imm_branch_offset,
    input  logic        ex_ready,
    input  logic [7:0]  busy_mask,
    input  logic        wb_we,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        id_valid,
    output logic [7:0]  id_pc,
    output logic [3:0]  id_opcode,
    output logic [2:0]  id_funct,
    output logic [2:0]  id_rd,
    output logic [15:0] id_rs_data,
    output logic [15:0] id_rt_data,
    output logic [15:0] id_imm
);
    // state | meaning
    // RUN   | normal flow
    // STALL | hazard or backpressure seen; fetch off, IF/ID held
    // FLUSH | cycle after a taken branch; wrong-path IF/ID content dropped
    // HALT  | HALT issued; fetch off until reset
    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state_q, state_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [7:0]  ifid_pc_q, ifid_pc_d;
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic        idex_valid_q, idex_valid_d;
    logic [7:0]  idex_pc_q, idex_pc_d;
    logic [3:0]  idex_op_q, idex_op_d;
    logic [2:0]  idex_funct_q, idex_funct_d;
    logic [2:0]  idex_rd_q, idex_rd_d;
    logic [15:0] idex_rs_q, idex_rs_d;
    logic [15:0] idex_rt_q, idex_rt_d;
    logic [15:0] idex_imm_q, idex_imm_d;
    logic [15:0] rf_q [8];

    logic [3:0]  opcode;
    logic [2:0]  rs, rt, rd_dec;
    logic [15:0] rs_data, rt_data;
    logic        uses_rs, uses_rt, rs_busy, rt_busy;
    logic        dec_valid, hazard, backpressure, stall, is_branch, taken, issue;

    assign opcode  = ifid_instr_q[15:12];
    assign rs      = ifid_instr_q[11:9];
    assign rt      = ifid_instr_q[8:6];

    // Write-through so a same-cycle writeback is seen by decode.
    assign rs_data = (rs == 3'd0) ? 16'h0 : (wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
    assign rt_data = (rt == 3'd0) ? 16'h0 : (wb_we && wb_addr == rt) ? wb_data : rf_q[rt];

    assign uses_rs = opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
    assign uses_rt = opcode inside {OP_R, OP_SW, OP_BEQ, OP_BNE};
    assign rs_busy = (rs != 3'd0) && (busy_mask[rs] || (idex_valid_q && idex_rd_q == rs));
    assign rt_busy = (rt != 3'd0) && (busy_mask[rt] || (idex_valid_q && idex_rd_q == rt));

    assign dec_valid    = ifid_valid_q && (state_q == RUN || state_q == STALL);
    assign hazard       = dec_valid && ((uses_rs && rs_busy) || (uses_rt && rt_busy));
    assign backpressure = idex_valid_q && !ex_ready;
    assign stall        = hazard || backpressure;
    assign is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign taken        = dec_valid && !stall &&
                          (((opcode == OP_BEQ) && (rs_data == rt_data)) ||
                           ((opcode == OP_BNE) && (rs_data != rt_data)));
    assign issue        = dec_valid && !stall && !is_branch;

    always_comb begin
        case (opcode)
            OP_R:          rd_dec = ifid_instr_q[5:3];
            OP_ADDI, OP_LW: rd_dec = rt;
            default:       rd_dec = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        if (state_q == HALT)                      state_d = HALT;
        else if (issue && opcode == OP_HALT)      state_d = HALT;
        else if (taken)                           state_d = FLUSH;
        else if (state_q != FLUSH && stall)       state_d = STALL;
    end

    always_comb begin
        instr_fetch_enable = 1'b0;
        branch_enable      = 1'b0;
        imm_branch_offset  = 6'h0;
        if (taken) begin
            instr_fetch_enable = 1'b1;
            branch_enable      = 1'b1;
            imm_branch_offset  = ifid_instr_q[5:0];
        end else if (state_q == RUN && !stall) begin
            instr_fetch_enable = 1'b1;
        end
    end

    always_comb begin
        ifid_valid_d = 1'b0;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        if (instr_fetch_enable) begin
            ifid_valid_d = if_valid;
            ifid_pc_d    = if_pc;
            ifid_instr_d = if_instr;
        end else if (dec_valid && stall) begin
            ifid_valid_d = 1'b1;
        end
    end

    always_comb begin
        idex_valid_d = 1'b0;
        idex_pc_d    = idex_pc_q;
        idex_op_d    = idex_op_q;
        idex_funct_d = idex_funct_q;
        idex_rd_d    = idex_rd_q;
        idex_rs_d    = idex_rs_q;
        idex_rt_d    = idex_rt_q;
        idex_imm_d   = idex_imm_q;
        if (backpressure) begin
            idex_valid_d = 1'b1;
        end else if (issue) begin
            idex_valid_d = 1'b1;
            idex_pc_d    = ifid_pc_q;
            idex_op_d    = opcode;
            idex_funct_d = ifid_instr_q[2:0];
            idex_rd_d    = rd_dec;
            idex_rs_d    = rs_data;
            idex_rt_d    = rt_data;
            idex_imm_d   = {{10{ifid_instr_q[5]}}, ifid_instr_q[5:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 8'h0;
            ifid_instr_q <= 16'h0;
            idex_valid_q <= 1'b0;
            idex_pc_q    <= 8'h0;
            idex_op_q    <= 4'h0;
            idex_funct_q <= 3'h0;
            idex_rd_q    <= 3'h0;
            idex_rs_q    <= 16'h0;
            idex_rt_q    <= 16'h0;
            idex_imm_q   <= 16'h0;
            for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0;
        end else begin
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            idex_valid_q <= idex_valid_d;
            idex_pc_q    <= idex_pc_d;
            idex_op_q    <= idex_op_d;
            idex_funct_q <= idex_funct_d;
            idex_rd_q    <= idex_rd_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_imm_q   <= idex_imm_d;
            if (wb_we && wb_addr != 3'd0) rf_q[wb_addr] <= wb_data;
        end
    end

    assign id_valid   = idex_valid_q;
    assign id_pc      = idex_pc_q;
    assign id_opcode  = idex_op_q;
    assign id_funct   = idex_funct_q;
    assign id_rd      = idex_rd_q;
    assign id_rs_data = idex_rs_q;
    assign id_rt_data = idex_rt_q;
    assign id_imm     = idex_imm_q;
endmodule
